// File: rtl/matmul_scheduler_if.sv
// Bundle between matmul_scheduler and its host, the shared inner_product unit and the
// A/B/C matrix storage. master = scheduler side, slave = everything around it.
interface matmul_scheduler_if #(
  parameter int IDX_W = 2
);
  logic                 start_i_stb;
  logic                 start_i_ack;
  logic                 done_o_stb;
  logic                 done_o_ack;
  logic                 err;
  logic [IDX_W-1:0]     row_sel;
  logic [IDX_W-1:0]     col_sel;
  logic                 ip_row_stb;
  logic                 ip_col_stb;
  logic                 ip_out_ack;
  logic                 ip_row_ack;
  logic                 ip_col_ack;
  logic                 ip_out_stb;
  logic [31:0]          ip_out;
  logic                 c_we;
  logic [2*IDX_W-1:0]   c_addr;
  logic [31:0]          c_data;

  modport master (
    input  start_i_stb, done_o_ack, ip_row_ack, ip_col_ack, ip_out_stb, ip_out,
    output start_i_ack, done_o_stb, err, row_sel, col_sel,
           ip_row_stb, ip_col_stb, ip_out_ack, c_we, c_addr, c_data
  );

  modport slave (
    output start_i_stb, done_o_ack, ip_row_ack, ip_col_ack, ip_out_stb, ip_out,
    input  start_i_ack, done_o_stb, err, row_sel, col_sel,
           ip_row_stb, ip_col_stb, ip_out_ack, c_we, c_addr, c_data
  );
endinterface

// File: rtl/matmul_scheduler.sv
// Walks all (row, col) pairs of C = A * B through one shared inner_product unit,
// writing each result to C row-major, with a per-wait-state watchdog abort.
module matmul_scheduler #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  matmul_scheduler_if.master bus
);

  // state    | meaning
  // IDLE     | waiting for start_i_stb
  // ISSUE    | raise operand strobes and out_ack, arm watchdog
  // WAIT_ACK | hold strobes until row and column acks coincide
  // WAIT_RES | wait for ip_out_stb, capture the result
  // WRITE    | one-cycle C write of the captured result
  // DRAIN    | wait for inner_product to drop ip_out_stb
  // NEXT     | advance col/row, finish after the last element
  // DONE     | hold done_o_stb/err until done_o_ack
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_NEXT     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
  localparam logic [15:0]        WDOG_LOAD = 16'(TIMEOUT - 1);
  localparam logic [2*IDX_W-1:0] N_W       = (2*IDX_W)'(N);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [15:0]      wdog_q, wdog_d;
  logic [31:0]      c_data_q, c_data_d;
  logic             err_q, err_d;
  logic             start_ack_q, start_ack_d;
  logic             done_q, done_d;
  logic             row_stb_q, row_stb_d;
  logic             col_stb_q, col_stb_d;
  logic             out_ack_q, out_ack_d;
  logic             c_we_q, c_we_d;
  logic             wdog_expired;

  // Down-counter reloaded on entry to each wait state; zero marks the last allowed cycle.
  assign wdog_expired = (wdog_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wdog_d      = wdog_q;
    c_data_d    = c_data_q;
    err_d       = err_q;
    done_d      = done_q;
    row_stb_d   = row_stb_q;
    col_stb_d   = col_stb_q;
    out_ack_d   = out_ack_q;
    start_ack_d = 1'b0;
    c_we_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i_stb) begin
          start_ack_d = 1'b1;
          row_d       = '0;
          col_d       = '0;
          err_d       = 1'b0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        row_stb_d = 1'b1;
        col_stb_d = 1'b1;
        out_ack_d = 1'b1;
        wdog_d    = WDOG_LOAD;
        state_d   = S_WAIT_ACK;
      end

      // The handshake is tested first so an ack in the expiry cycle still wins.
      S_WAIT_ACK: begin
        if (bus.ip_row_ack && bus.ip_col_ack) begin
          row_stb_d = 1'b0;
          col_stb_d = 1'b0;
          wdog_d    = WDOG_LOAD;
          state_d   = S_WAIT_RES;
        end else if (wdog_expired) begin
          row_stb_d = 1'b0;
          col_stb_d = 1'b0;
          out_ack_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q - 16'd1;
        end
      end

      S_WAIT_RES: begin
        if (bus.ip_out_stb) begin
          c_data_d  = bus.ip_out;
          out_ack_d = 1'b0;
          c_we_d    = 1'b1;
          state_d   = S_WRITE;
        end else if (wdog_expired) begin
          row_stb_d = 1'b0;
          col_stb_d = 1'b0;
          out_ack_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q - 16'd1;
        end
      end

      S_WRITE: begin
        state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (!bus.ip_out_stb) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (col_q == LAST_IDX) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (row_q == LAST_IDX && col_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_DONE: begin
        if (bus.done_o_ack) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      wdog_q      <= '0;
      c_data_q    <= '0;
      err_q       <= 1'b0;
      start_ack_q <= 1'b0;
      done_q      <= 1'b0;
      row_stb_q   <= 1'b0;
      col_stb_q   <= 1'b0;
      out_ack_q   <= 1'b0;
      c_we_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wdog_q      <= wdog_d;
      c_data_q    <= c_data_d;
      err_q       <= err_d;
      start_ack_q <= start_ack_d;
      done_q      <= done_d;
      row_stb_q   <= row_stb_d;
      col_stb_q   <= col_stb_d;
      out_ack_q   <= out_ack_d;
      c_we_q      <= c_we_d;
    end
  end

  assign bus.start_i_ack = start_ack_q;
  assign bus.done_o_stb  = done_q;
  assign bus.err         = err_q;
  assign bus.row_sel     = row_q;
  assign bus.col_sel     = col_q;
  assign bus.ip_row_stb  = row_stb_q;
  assign bus.ip_col_stb  = col_stb_q;
  assign bus.ip_out_ack  = out_ack_q;
  assign bus.c_we        = c_we_q;
  assign bus.c_addr      = (2*IDX_W)'(row_q) * N_W + (2*IDX_W)'(col_q);
  assign bus.c_data      = c_data_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Scoreboard bench for matmul_scheduler: an inner_product/storage model answers the
// scheduler, expected C writes and done/err outcomes are queued by the stimulus.
module tb_matmul_scheduler;
  localparam int N       = 2;
  localparam int IDX_W   = 1;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matmul_scheduler_if #(.IDX_W(IDX_W)) ifc();

  matmul_scheduler #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct { int r; int c; logic [31:0] data; } wr_t;
  typedef struct { logic err; int lat_kind; } dn_t;  // lat_kind: 0 none, 1 from WAIT_RES, 2 from WAIT_ACK

  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  logic [31:0] vals [N][N];
  int  row_dly = 0, col_dly = 0, res_dly = 0;
  bit  never_res = 0;
  bit  starting = 0;
  bit  noise_en = 0;
  int  writes_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] int_to_f32(input int unsigned k);
    int e = 0;
    if (k == 0) return 32'h0;
    while ((k >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((k << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  task automatic check_outputs_zero(input string name);
    check(name, {ifc.start_i_ack, ifc.done_o_stb, ifc.err, ifc.row_sel, ifc.col_sel,
                 ifc.ip_row_stb, ifc.ip_col_stb, ifc.ip_out_ack, ifc.c_we, ifc.c_addr,
                 ifc.c_data}, 64'h0);
  endtask

  // inner_product + A/B storage model; drives just after the rising edge.
  initial begin : ip_model
    int phase = 0;
    int cnt = 0;
    int cr = 0, cc = 0;
    ifc.ip_row_ack = 1'b0; ifc.ip_col_ack = 1'b0; ifc.ip_out_stb = 1'b0; ifc.ip_out = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        ifc.ip_row_ack = 1'b0; ifc.ip_col_ack = 1'b0; ifc.ip_out_stb = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (ifc.ip_row_stb) begin
               cr = int'(ifc.row_sel); cc = int'(ifc.col_sel); cnt = 0; phase = 1;
               ifc.ip_row_ack = (row_dly == 0);
               ifc.ip_col_ack = (col_dly == 0);
             end
          1: if (!ifc.ip_row_stb) begin
               ifc.ip_row_ack = 1'b0; ifc.ip_col_ack = 1'b0; cnt = 0; phase = 2;
               if (ifc.ip_out_ack && !never_res && res_dly == 0) begin
                 ifc.ip_out_stb = 1'b1; ifc.ip_out = vals[cr][cc]; phase = 3;
               end
             end else begin
               cnt++;
               ifc.ip_row_ack = (cnt >= row_dly);
               ifc.ip_col_ack = (cnt >= col_dly);
             end
          2: if (!ifc.ip_out_ack) phase = 0;
             else begin
               cnt++;
               if (!never_res && cnt >= res_dly) begin
                 ifc.ip_out_stb = 1'b1; ifc.ip_out = vals[cr][cc]; phase = 3;
               end
             end
          default: if (!ifc.ip_out_ack) begin ifc.ip_out_stb = 1'b0; phase = 0; end
        endcase
      end
    end
  end

  initial begin : monitor
    logic p_row_stb = 1'b0, p_both = 1'b0, p_done = 1'b0;
    int t_wack = 0, t_wres = 0;
    wr_t e;
    dn_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_row_stb = 1'b0; p_both = 1'b0; p_done = 1'b0;
      end else begin
        if (ifc.ip_row_stb && !p_row_stb) t_wack = cyc;
        if (!ifc.ip_row_stb && p_row_stb && !ifc.done_o_stb) begin
          check("accept_needs_both_acks", p_both, 1);
          t_wres = cyc;
        end
        if (ifc.c_we) begin
          writes_seen++;
          if (exp_wr.size() == 0) check("unexpected_c_we", 1, 0);
          else begin
            e = exp_wr.pop_front();
            check("c_addr", ifc.c_addr, e.r * N + e.c);
            check("c_data", ifc.c_data, e.data);
            check("sel_at_write", {ifc.row_sel, ifc.col_sel}, {IDX_W'(e.r), IDX_W'(e.c)});
          end
        end
        if (ifc.done_o_stb && !p_done) begin
          if (exp_dn.size() == 0) check("unexpected_done", 1, 0);
          else begin
            d = exp_dn.pop_front();
            check("done_err", ifc.err, d.err);
            check("writes_pending_at_done", exp_wr.size(), 0);
            check("ip_strobes_at_done", {ifc.ip_row_stb, ifc.ip_col_stb, ifc.ip_out_ack}, 3'b000);
            if (d.lat_kind == 1) check("abort_lat_wait_res", cyc - t_wres, TIMEOUT);
            if (d.lat_kind == 2) check("abort_lat_wait_ack", cyc - t_wack, TIMEOUT);
          end
        end
        if (ifc.start_i_stb && !starting) check("start_ack_while_busy", ifc.start_i_ack, 0);
        p_row_stb = ifc.ip_row_stb;
        p_both    = ifc.ip_row_ack && ifc.ip_col_ack;
        p_done    = ifc.done_o_stb;
      end
    end
  end

  // Random host noise during a job: stray start requests and done acks must be ignored.
  initial begin : noise
    forever begin
      @(negedge clk);
      if (noise_en) begin
        if (ifc.done_o_stb) begin
          ifc.done_o_ack = 1'b0; ifc.start_i_stb = 1'b0;
        end else begin
          ifc.done_o_ack  = 1'($urandom_range(0, 1));
          ifc.start_i_stb = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic push_job(input int upto, input logic err, input int lat_kind, input bit with_done);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r * N + c < upto) exp_wr.push_back('{r: r, c: c, data: vals[r][c]});
    if (with_done) exp_dn.push_back('{err: err, lat_kind: lat_kind});
  endtask

  task automatic rand_vals();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) vals[r][c] = $urandom;
  endtask

  task automatic start_job();
    int k = 0;
    starting = 1;
    ifc.start_i_stb = 1'b1;
    do begin @(negedge clk); k++; end while (!ifc.start_i_ack && k < 20);
    check("start_ack_latency", k, 1);
    ifc.start_i_stb = 1'b0;
    starting = 0;
    @(negedge clk);
    check("start_ack_pulse", ifc.start_i_ack, 0);
  endtask

  task automatic finish_job(input int hold, input bit hold_start);
    int k = 0;
    while (!ifc.done_o_stb && k < 2000) begin @(negedge clk); k++; end
    noise_en = 0;
    ifc.done_o_ack = 1'b0;
    ifc.start_i_stb = 1'b0;
    if (!ifc.done_o_stb) begin
      check("done_timeout", 0, 1);
      return;
    end
    ifc.start_i_stb = hold_start;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", ifc.done_o_stb, 1);
      if (hold_start) check("start_ack_in_done", ifc.start_i_ack, 0);
    end
    ifc.start_i_stb = 1'b0;
    ifc.done_o_ack = 1'b1;
    @(negedge clk);
    ifc.done_o_ack = 1'b0;
    check("done_cleared", ifc.done_o_stb, 0);
  endtask

  initial begin : main
    int k;
    int w0;
    ifc.start_i_stb = 1'b0;
    ifc.done_o_ack  = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);

    // Directed job: result = 4*row+col+1.0, then done held for 20 cycles.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) vals[r][c] = int_to_f32(4 * r + c + 1);
    row_dly = 1; col_dly = 1; res_dly = 10; never_res = 0;
    push_job(N * N, 1'b0, 0, 1);
    start_job();
    finish_job(20, 1);

    // Result never arrives: watchdog abort out of WAIT_RES.
    never_res = 1;
    push_job(0, 1'b1, 1, 1);
    start_job();
    finish_job(0, 0);
    never_res = 0;

    // Row ack three cycles ahead of column ack.
    rand_vals();
    row_dly = 1; col_dly = 4; res_dly = 2;
    push_job(N * N, 1'b0, 0, 1);
    start_job();
    finish_job(1, 0);

    // Acks and results arriving in the watchdog expiry cycle are accepted.
    rand_vals();
    row_dly = TIMEOUT - 1; col_dly = TIMEOUT - 1; res_dly = TIMEOUT - 1;
    push_job(N * N, 1'b0, 0, 1);
    start_job();
    finish_job(0, 0);

    // One cycle later is too late: abort out of WAIT_ACK.
    row_dly = 0; col_dly = TIMEOUT; res_dly = 0;
    push_job(0, 1'b1, 2, 1);
    start_job();
    finish_job(0, 0);

    // Reset during WAIT_RES of element 2: job abandoned, no done, no further writes.
    rand_vals();
    row_dly = 0; col_dly = 0; res_dly = 8;
    push_job(2, 1'b0, 0, 0);
    w0 = writes_seen;
    start_job();
    k = 0;
    while (writes_seen < w0 + 2 && k < 500) begin @(negedge clk); k++; end
    while (!(ifc.ip_out_ack && !ifc.ip_row_stb) && k < 500) begin @(negedge clk); k++; end
    check("reached_elem2_wait_res", k < 500, 1);
    rst = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    check("writes_pending_at_reset", exp_wr.size(), 0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held_outputs");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_outputs_zero("idle_after_reset");

    // Randomized jobs with host noise.
    for (int j = 0; j < 6; j++) begin
      rand_vals();
      row_dly = $urandom_range(0, 4);
      col_dly = $urandom_range(0, 4);
      res_dly = $urandom_range(0, 8);
      push_job(N * N, 1'b0, 0, 1);
      start_job();
      noise_en = 1;
      finish_job($urandom_range(0, 3), 0);
    end

    repeat (4) @(negedge clk);
    check("leftover_writes", exp_wr.size(), 0);
    check("leftover_dones", exp_dn.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
